seq_fullsub: RTL and testbench
==============================

Name: seq_fullsub

Overview:
- Parametrised, multi-cycle successor to the single-bit full subtractor.
- Subtracts two WIDTH-bit operands plus a borrow-in, SLICE bits per clock, using a registered borrow chain between slices.
- Returns difference, borrow-out and signed overflow through valid/ready handshakes.
- Used in the arithmetic datapath where a full-width combinational borrow chain would miss timing.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SLICE, 8, bits processed per cycle. WIDTH % SLICE must be 0, otherwise elaboration fails via $error.
- NSLICE, WIDTH/SLICE, derived localparam; not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and borrow-in present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  output  1  unsigned borrow-out; 1 iff a < b + bin.
- ovf  output  1  signed overflow of a - b - bin.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset state: IDLE, in_ready=1, out_valid=0, diff=0, bout=0, ovf=0, slice counter=0, borrow register=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - When in_valid && in_ready: latch a, b, bin; borrow register := bin; counter := 0; go to RUN.
- RUN: in_ready=0, out_valid=0.
  - Each cycle, slice k = counter computes a[k] - b[k] - borrow for that SLICE-bit field.
  - Writes result field k of diff; borrow register := slice borrow; counter increments.
  - On the cycle counter == NSLICE-1: bout := final borrow; ovf := (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]); go to DONE.
- DONE: out_valid=1; diff, bout and ovf are held stable.
  - When out_ready=1: go to IDLE.
  - in_ready stays 0 in DONE, so a new accept never coincides with result handoff. The earliest next accept is the cycle after leaving DONE.
- Latency: accept at edge N gives out_valid high after edge N+NSLICE. Throughput is one operation per NSLICE+2 cycles when out_ready is held high.
- NSLICE=1 is legal: one RUN cycle.
- Outputs diff, bout and ovf change only on entry to DONE (diff slices update internally in RUN); they are don't-care while out_valid=0.
- Reset mid-operation (RUN or DONE): abort immediately to reset state. No result is produced and the partial result is discarded.
- Wrap-around: diff wraps modulo 2^WIDTH. 0 - 1 gives all ones with bout=1.
- Inputs a, b and bin are ignored outside IDLE.

Optional Feature:
- Macro: SEQ_FULLSUB_SAT_EN.
- Defined: adds input port sat (1 bit, sampled on accept).
  - If sat=1 and ovf=1, diff saturates: to 2^(WIDTH-1)-1 when a is non-negative, else to -2^(WIDTH-1).
  - ovf still reports the overflow; bout is unaffected.
  - Saturation is applied on the DONE entry edge and adds no latency.
- Undefined: no sat port; diff always wraps.

Decomposition:
- Package seq_fullsub_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - function computing the saturated max/min for a given WIDTH.
- Sub-module fullsub_slice: combinational SLICE-bit subtract.
  - Inputs x[SLICE], y[SLICE], bi; outputs d[SLICE], bo.
  - Instantiated once and time-multiplexed over slices.

Test Plan (WIDTH=32, SLICE=8; NSLICE=4):
- a=0x00000005, b=0x00000003, bin=0, accept at cycle 0 -> out_valid at cycle 4; diff=0x00000002, bout=0, ovf=0.
- a=0x00000000, b=0x00000001, bin=0 -> diff=0xFFFFFFFF, bout=1, ovf=0; borrow ripples through all 4 slices.
- a=b=0x12345678, bin=1 -> diff=0xFFFFFFFF, bout=1, ovf=0.
- a=0x80000000, b=0x00000001 -> diff=0x7FFFFFFF, ovf=1, bout=0. With SEQ_FULLSUB_SAT_EN and sat=1 -> diff=0x80000000, ovf=1.
- Result ready, out_ready=0 for 5 cycles, then 1 -> out_valid, diff, bout and ovf stable all 5 cycles; in_ready=0 throughout; in_ready=1 the cycle after the handoff.
- rst=1 asserted during RUN at counter=2 -> next cycle in_ready=1, out_valid=0, diff=0. A fresh op accepted afterwards completes correctly with no stale borrow.

Source files
------------

// File: rtl/seq_fullsub_pkg.sv
// Shared types and helpers for the sequential full subtractor.
package seq_fullsub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Widest operand the saturation helper can describe.
  localparam int unsigned SAT_MAX_W = 256;

  // Signed saturation limit for a WIDTH-bit result: -2^(WIDTH-1) when neg,
  // else 2^(WIDTH-1)-1. Bits above WIDTH are don't-care for the caller.
  function automatic logic [SAT_MAX_W-1:0] sat_limit(input int unsigned width,
                                                     input logic        neg);
    logic [SAT_MAX_W-1:0] v;
    v = SAT_MAX_W'(1) << (width - 1);
    if (!neg) begin
      v = v - SAT_MAX_W'(1);
    end
    return v;
  endfunction

endpackage

// File: rtl/seq_fullsub_slice.sv
// Combinational SLICE-bit subtractor: d = x - y - bi, bo = borrow out.
module fullsub_slice #(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             bi,
  output logic [SLICE-1:0] d,
  output logic             bo
);

  logic [SLICE:0] w_r;

  // One extra bit catches the borrow as the sign of the widened difference.
  assign w_r = {1'b0, x} - {1'b0, y} - {{SLICE{1'b0}}, bi};
  assign d   = w_r[SLICE-1:0];
  assign bo  = w_r[SLICE];

endmodule

// File: rtl/seq_fullsub.sv
// Multi-cycle WIDTH-bit subtractor, SLICE bits per clock, with a registered
// borrow chain and valid/ready handshakes on both sides.
// Optional: define SEQ_FULLSUB_SAT_EN to add the 'sat' input, which clamps
// diff to the signed limit on overflow.
module seq_fullsub
  import seq_fullsub_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
`ifdef SEQ_FULLSUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (SLICE == 0 || (WIDTH % SLICE) != 0) begin : g_bad_slice
    $error("seq_fullsub: WIDTH (%0d) must be a multiple of SLICE (%0d)", WIDTH, SLICE);
  end
`ifdef SEQ_FULLSUB_SAT_EN
  if (WIDTH > SAT_MAX_W) begin : g_bad_width
    $error("seq_fullsub: WIDTH (%0d) exceeds saturation helper range", WIDTH);
  end
`endif

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_borrow;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_work;
  logic [WIDTH-1:0]   r_diff;
  logic               r_bout;
  logic               r_ovf;
`ifdef SEQ_FULLSUB_SAT_EN
  logic               r_sat;
`endif

  logic               w_accept;
  logic               w_last;
  logic [SLICE-1:0]   w_x;
  logic [SLICE-1:0]   w_y;
  logic [SLICE-1:0]   w_d;
  logic               w_bo;
  logic [WIDTH-1:0]   w_diff_full;
  logic [WIDTH-1:0]   w_result;
  logic               w_ovf;

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_cnt == CNT_W'(NSLICE - 1));

  // Select the operand fields for the slice being processed this cycle.
  always_comb begin
    w_x = r_a[int'(r_cnt) * SLICE +: SLICE];
    w_y = r_b[int'(r_cnt) * SLICE +: SLICE];
  end

  fullsub_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .x  (w_x),
    .y  (w_y),
    .bi (r_borrow),
    .d  (w_d),
    .bo (w_bo)
  );

  // Full-width result including the slice finishing this cycle, so overflow
  // and saturation can be resolved on the DONE entry edge without extra latency.
  always_comb begin
    w_diff_full = r_work;
    w_diff_full[int'(r_cnt) * SLICE +: SLICE] = w_d;
    w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff_full[WIDTH-1] != r_a[WIDTH-1]);
    w_result = w_diff_full;
`ifdef SEQ_FULLSUB_SAT_EN
    if (r_sat && w_ovf) begin
      w_result = WIDTH'(sat_limit(WIDTH, r_a[WIDTH-1]));
    end
`endif
  end

  // Next-state logic for the IDLE -> RUN -> DONE cycle.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture, slice iteration and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_work   <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
`ifdef SEQ_FULLSUB_SAT_EN
      r_sat    <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_a      <= a;
        r_b      <= b;
        r_borrow <= bin;
        r_cnt    <= '0;
        r_work   <= '0;
`ifdef SEQ_FULLSUB_SAT_EN
        r_sat    <= sat;
`endif
      end else if (r_state == RUN) begin
        r_work   <= w_diff_full;
        r_borrow <= w_bo;
        r_cnt    <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_diff <= w_result;
          r_bout <= w_bo;
          r_ovf  <= w_ovf;
        end
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_seq_fullsub.sv
// Directed self-checking bench for seq_fullsub (WIDTH=32, SLICE=8).
module tb_seq_fullsub;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned SLICE  = 8;
  localparam int unsigned NSLICE = 4;
`ifdef SEQ_FULLSUB_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
`ifdef SEQ_FULLSUB_SAT_EN
  logic             sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_fullsub #(
    .WIDTH (WIDTH),
    .SLICE (SLICE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
`ifdef SEQ_FULLSUB_SAT_EN
    .sat       (sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  // Accept one operation (caller is at posedge+1 in IDLE) and step to the
  // first DONE cycle, checking latency and result.
  task automatic run_op(input string name, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic tbin, input logic [31:0] ed, input logic eb, input logic eo);
    a = ta; b = tb_v; bin = tbin; in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s accept_ready got %b want 1", name, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 32'hDEADBEEF; b = 32'h0BADF00D; bin = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL %s run_start got valid=%b ready=%b want 0 0", name, out_valid, in_ready);
    end
    for (int i = 0; i < int'(NSLICE) - 1; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL %s early_valid cycle %0d got %b want 0", name, i + 1, out_valid);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL %s latency got valid=%b want 1", name, out_valid);
    end
    checks++;
    if (diff !== ed) begin
      errors++; $display("FAIL %s diff got %h want %h", name, diff, ed);
    end
    checks++;
    if (bout !== eb || ovf !== eo) begin
      errors++; $display("FAIL %s flags got bout=%b ovf=%b want %b %b", name, bout, ovf, eb, eo);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL %s done_ready got %b want 0", name, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; bin = 1'b0;
`ifdef SEQ_FULLSUB_SAT_EN
    sat = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hs got ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
    checks++;
    if (diff !== 32'h0 || bout !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("FAIL reset_out got diff=%h bout=%b ovf=%b want 0 0 0", diff, bout, ovf);
    end
  endtask

  // Back-to-back vectors with out_ready held high; each new accept lands in
  // the cycle right after the handoff.
  task automatic test_vectors();
    logic [31:0] va   [6] = '{32'h00000005, 32'h00000000, 32'h12345678, 32'h80000000, 32'h7FFFFFFF, 32'h00000100};
    logic [31:0] vb   [6] = '{32'h00000003, 32'h00000001, 32'h12345678, 32'h00000001, 32'hFFFFFFFF, 32'h00000001};
    logic        vbin [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] vd   [6] = '{32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h000000FF};
    logic [31:0] vds  [6] = '{32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h000000FF};
    logic        vbo  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        vov  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), va[i], vb[i], vbin[i], SAT_ON ? vds[i] : vd[i], vbo[i], vov[i]);
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++; $display("FAIL vec%0d handoff got ready=%b valid=%b want 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    run_op("bp", 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
    in_valid = 1'b1; a = 32'h11111111; b = 32'h22222222;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== 32'hFFFFFFFF || bout !== 1'b1 || ovf !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got valid=%b ready=%b diff=%h bout=%b ovf=%b want 1 0 ffffffff 1 0",
                 i, out_valid, in_ready, diff, bout, ovf);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    out_ready = 1'b1;
    a = 32'h00000000; b = 32'h00000001; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 32'h0) begin
      errors++; $display("FAIL midrst got ready=%b valid=%b diff=%h want 1 0 0", in_ready, out_valid, diff);
    end
    run_op("after_rst", 32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
